// File: rtl/force_wb_router_if.sv
// force_wb_router_if
//   Bundles the force-writeback router's data-path signals.
//   master : upstream/test side (drives wb_in, wb_valid, net_ready)
//   slave  : router side
//   wb_in/wb_valid/wb_ready       force writeback packet handshake
//   local_wr_en/addr/data         home-cell force-cache write port
//   net_out/net_valid/net_ready   FWFT remote FIFO head toward the network injector
//   remote_idle                   no remote packets held or arriving
//   bad_id_err/overflow_err       sticky error flags
interface force_wb_router_if #(
    parameter int DATA_WIDTH        = 32,
    parameter int CELL_ID_WIDTH     = 3,
    parameter int PARTICLE_ID_WIDTH = 7,
    parameter int NODE_ID_WIDTH     = 5
);
    localparam int ID_WIDTH  = 3*CELL_ID_WIDTH + PARTICLE_ID_WIDTH;
    localparam int WB_WIDTH  = ID_WIDTH + 3*DATA_WIDTH;
    localparam int NET_WIDTH = NODE_ID_WIDTH + PARTICLE_ID_WIDTH + 3*DATA_WIDTH;

    logic [WB_WIDTH-1:0]          wb_in;
    logic                         wb_valid;
    logic                         wb_ready;
    logic                         local_wr_en;
    logic [PARTICLE_ID_WIDTH-1:0] local_wr_addr;
    logic [3*DATA_WIDTH-1:0]      local_wr_data;
    logic [NET_WIDTH-1:0]         net_out;
    logic                         net_valid;
    logic                         net_ready;
    logic                         remote_idle;
    logic                         bad_id_err;
    logic                         overflow_err;

    modport master (
        output wb_in, wb_valid, net_ready,
        input  wb_ready, local_wr_en, local_wr_addr, local_wr_data,
               net_out, net_valid, remote_idle, bad_id_err, overflow_err
    );

    modport slave (
        input  wb_in, wb_valid, net_ready,
        output wb_ready, local_wr_en, local_wr_addr, local_wr_data,
               net_out, net_valid, remote_idle, bad_id_err, overflow_err
    );
endinterface

// File: rtl/force_wb_router.sv
// force_wb_router
//   Sits behind the force distributor. Home-cell (2,2,2) writebacks go to the
//   local force-cache write port one cycle later; every other legal cell is
//   mapped to a ring node ID and queued in a FWFT FIFO for the network injector.
// Ports
//   clk, rst : clock, synchronous active-high reset
//   bus      : force_wb_router_if.slave (packet in, local write, network out,
//              ready/idle/error status)
// Optional feature: define FORCE_WB_ROUTER_STATS_EN to add
//   local_pkt_cnt[15:0], remote_pkt_cnt[15:0] (saturating packet counters) and
//   max_fifo_occ (peak FIFO occupancy). Core behaviour is unchanged.
module force_wb_router #(
    parameter int          DATA_WIDTH        = 32,
    parameter int          CELL_ID_WIDTH     = 3,
    parameter int          PARTICLE_ID_WIDTH = 7,
    parameter int          NODE_ID_WIDTH     = 5,
    parameter int          FIFO_DEPTH        = 16,
    parameter int          AFULL_MARGIN      = 2,
    parameter logic [8:0]  CELL_222          = 9'b010010010
) (
    input  logic                  clk,
    input  logic                  rst,
    force_wb_router_if.slave      bus
`ifdef FORCE_WB_ROUTER_STATS_EN
    ,
    output logic [15:0]                   local_pkt_cnt,
    output logic [15:0]                   remote_pkt_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   max_fifo_occ
`endif
);
    localparam int CW        = CELL_ID_WIDTH;
    localparam int PW        = PARTICLE_ID_WIDTH;
    localparam int FW        = 3*DATA_WIDTH;
    localparam int NET_WIDTH = NODE_ID_WIDTH + PW + FW;
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int CNTW      = AW + 1;

    // ---------------- decode ----------------
    logic [CW-1:0]          cx, cy, cz;
    logic [PW-1:0]          pid;
    logic [FW-1:0]          force_v;
    logic [NODE_ID_WIDTH-1:0] node_id;
    logic                   legal, is_home, local_hit, remote_hit, bad_hit;

    always_comb begin
        cx      = bus.wb_in[FW+PW+3*CW-1 -: CW];
        cy      = bus.wb_in[FW+PW+2*CW-1 -: CW];
        cz      = bus.wb_in[FW+PW+CW-1   -: CW];
        pid     = bus.wb_in[FW +: PW];
        force_v = bus.wb_in[FW-1:0];
        legal   = (cx != '0) && (cx < CW'(4)) &&
                  (cy != '0) && (cy < CW'(4)) &&
                  (cz != '0) && (cz < CW'(4));
        is_home = ({cx, cy, cz} == CELL_222);
        // Only meaningful for legal coordinates; illegal packets never use it.
        node_id = NODE_ID_WIDTH'((32'(cx) - 1) * 9 + (32'(cy) - 1) * 3 + (32'(cz) - 1));
        local_hit  = bus.wb_valid & legal & is_home;
        remote_hit = bus.wb_valid & legal & ~is_home;
        bad_hit    = bus.wb_valid & ~legal;
    end

    // ---------------- remote FIFO ----------------
    logic [NET_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CNTW-1:0]      count, count_next;
    logic                 pop, do_push, ovf_hit;

    // A push while full is still accepted if the head leaves the same cycle:
    // wr_ptr == rd_ptr then, and the head is read combinationally before the
    // write lands at the clock edge.
    always_comb begin
        pop     = (count != '0) & bus.net_ready;
        do_push = remote_hit & ((count != CNTW'(FIFO_DEPTH)) | pop);
        ovf_hit = remote_hit & (count == CNTW'(FIFO_DEPTH)) & ~pop;
        count_next = count;
        case ({do_push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {node_id, pid, force_v};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            bus.wb_ready     <= 1'b1;
            bus.overflow_err <= 1'b0;
            bus.bad_id_err   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count        <= count_next;
            // Registered ready: the margin absorbs packets already launched
            // against the previous cycle's ready.
            bus.wb_ready <= (count_next < CNTW'(FIFO_DEPTH - AFULL_MARGIN));
            if (ovf_hit) bus.overflow_err <= 1'b1;
            if (bad_hit) bus.bad_id_err   <= 1'b1;
        end
    end

    assign bus.net_valid   = (count != '0);
    assign bus.net_out     = mem[rd_ptr];
    assign bus.remote_idle = (count == '0) & ~remote_hit;

    // ---------------- local path ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.local_wr_en   <= 1'b0;
            bus.local_wr_addr <= '0;
            bus.local_wr_data <= '0;
        end else begin
            bus.local_wr_en <= local_hit;
            if (local_hit) begin
                bus.local_wr_addr <= pid;
                bus.local_wr_data <= force_v;
            end
        end
    end

`ifdef FORCE_WB_ROUTER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            local_pkt_cnt  <= '0;
            remote_pkt_cnt <= '0;
            max_fifo_occ   <= '0;
        end else begin
            if (local_hit && local_pkt_cnt != 16'hFFFF)  local_pkt_cnt  <= local_pkt_cnt + 1'b1;
            if (do_push && remote_pkt_cnt != 16'hFFFF)   remote_pkt_cnt <= remote_pkt_cnt + 1'b1;
            if (count_next > max_fifo_occ)               max_fifo_occ   <= count_next;
        end
    end
`endif
endmodule

// File: tb/tb_force_wb_router.sv
module tb_force_wb_router;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    force_wb_router_if bus();

`ifdef FORCE_WB_ROUTER_STATS_EN
    logic [15:0] local_pkt_cnt, remote_pkt_cnt;
    logic [4:0]  max_fifo_occ;
`endif

    force_wb_router dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FORCE_WB_ROUTER_STATS_EN
        ,
        .local_pkt_cnt  (local_pkt_cnt),
        .remote_pkt_cnt (remote_pkt_cnt),
        .max_fifo_occ   (max_fifo_occ)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [107:0] exp_q[$];
    logic [107:0] exp_w;

    function automatic logic [107:0] pkt(input logic [4:0] node, input logic [6:0] pid,
                                         input logic [95:0] f);
        return {node, pid, f};
    endfunction

    function automatic logic [4:0] node_of(input int x, input int y, input int z);
        return 5'((x - 1) * 9 + (y - 1) * 3 + (z - 1));
    endfunction

    // Called at a negedge; presents one packet for the next posedge.
    task automatic put(input logic [2:0] x, input logic [2:0] y, input logic [2:0] z,
                       input logic [6:0] pid, input logic [95:0] f);
        bus.wb_in    = {x, y, z, pid, f};
        bus.wb_valid = 1'b1;
        @(negedge clk);
        bus.wb_valid = 1'b0;
    endtask

    // Legal remote packet with a random cell, expectation queued.
    task automatic put_rand(input logic [6:0] pid, input bit expect_stored);
        int x, y, z;
        logic [95:0] f;
        do begin
            x = $urandom_range(1, 3); y = $urandom_range(1, 3); z = $urandom_range(1, 3);
        end while (x == 2 && y == 2 && z == 2);
        f = {$urandom, $urandom, $urandom};
        if (expect_stored) exp_q.push_back(pkt(node_of(x, y, z), pid, f));
        put(3'(x), 3'(y), 3'(z), pid, f);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_tests++; if (bus.wb_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wb_ready: got %b want 1", bus.wb_ready); end
        n_tests++; if (bus.remote_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", bus.remote_idle); end
        n_tests++; if (bus.net_valid !== 1'b0) begin n_fail++; $display("FAIL reset_net_valid: got %b want 0", bus.net_valid); end
        n_tests++; if (bus.local_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_local_en: got %b want 0", bus.local_wr_en); end
        n_tests++; if ({bus.bad_id_err, bus.overflow_err} !== 2'b00) begin n_fail++; $display("FAIL reset_errs: got %b want 00", {bus.bad_id_err, bus.overflow_err}); end
`ifdef FORCE_WB_ROUTER_STATS_EN
        n_tests++; if ({local_pkt_cnt, remote_pkt_cnt, max_fifo_occ} !== '0) begin n_fail++; $display("FAIL reset_stats: got %h/%h/%h want 0", local_pkt_cnt, remote_pkt_cnt, max_fifo_occ); end
`endif
    endtask

    task automatic test_local;
        put(3'd2, 3'd2, 3'd2, 7'd5, {32'h0, 32'h0, 32'h3F800000});
        n_tests++; if (bus.local_wr_en !== 1'b1) begin n_fail++; $display("FAIL local_en: got %b want 1", bus.local_wr_en); end
        n_tests++; if (bus.local_wr_addr !== 7'd5) begin n_fail++; $display("FAIL local_addr: got %0d want 5", bus.local_wr_addr); end
        n_tests++; if (bus.local_wr_data !== {32'h0, 32'h0, 32'h3F800000}) begin n_fail++; $display("FAIL local_data: got %h want 3f800000", bus.local_wr_data); end
        n_tests++; if (bus.net_valid !== 1'b0) begin n_fail++; $display("FAIL local_net_valid: got %b want 0", bus.net_valid); end
        @(negedge clk);
        n_tests++; if (bus.local_wr_en !== 1'b0) begin n_fail++; $display("FAIL local_en_drop: got %b want 0", bus.local_wr_en); end
`ifdef FORCE_WB_ROUTER_STATS_EN
        n_tests++; if (local_pkt_cnt !== 16'd1) begin n_fail++; $display("FAIL stats_local: got %0d want 1", local_pkt_cnt); end
`endif
    endtask

    task automatic test_remote_decode;
        logic [95:0] f1, f2, f3;
        f1 = 96'h111; f2 = 96'h222; f3 = 96'h333;
        bus.net_ready = 1'b0;
        exp_q.push_back(pkt(5'd0, 7'd3, f1));
        exp_q.push_back(pkt(5'd26, 7'd7, f2));
        exp_q.push_back(pkt(5'd21, 7'd9, f3));
        bus.wb_in = {3'd1, 3'd1, 3'd1, 7'd3, f1};
        bus.wb_valid = 1'b1;
        #1;
        n_tests++; if (bus.remote_idle !== 1'b0) begin n_fail++; $display("FAIL decode_idle: got %b want 0", bus.remote_idle); end
        @(negedge clk);
        bus.wb_valid = 1'b0;
        n_tests++; if (bus.net_valid !== 1'b1) begin n_fail++; $display("FAIL decode_fwft: got %b want 1", bus.net_valid); end
        put(3'd3, 3'd3, 3'd3, 7'd7, f2);
        put(3'd3, 3'd2, 3'd1, 7'd9, f3);
        bus.net_ready = 1'b1;
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) begin
            if (bus.net_valid) begin
                exp_w = exp_q.pop_front();
                n_tests++; if (bus.net_out !== exp_w) begin n_fail++; $display("FAIL decode_out: got %h want %h", bus.net_out, exp_w); end
            end
            @(negedge clk);
        end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL decode_drain: got %0d left want 0", exp_q.size()); exp_q.delete(); end
        bus.net_ready = 1'b0;
        n_tests++; if (bus.net_valid !== 1'b0) begin n_fail++; $display("FAIL decode_empty: got %b want 0", bus.net_valid); end
    endtask

    task automatic test_backpressure;
        bus.net_ready = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            put_rand(7'(k), 1'b1);
            n_tests++; if (bus.wb_ready !== (k < 14)) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want %b", k, bus.wb_ready, (k < 14)); end
        end
        n_tests++; if (bus.overflow_err !== 1'b0) begin n_fail++; $display("FAIL bp_ovf: got %b want 0", bus.overflow_err); end
        bus.net_ready = 1'b1;
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
            if (bus.net_valid) begin
                exp_w = exp_q.pop_front();
                n_tests++; if (bus.net_out !== exp_w) begin n_fail++; $display("FAIL bp_out: got %h want %h", bus.net_out, exp_w); end
            end
            @(negedge clk);
        end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d left want 0", exp_q.size()); exp_q.delete(); end
        bus.net_ready = 1'b0;
        n_tests++; if (bus.wb_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %b want 1", bus.wb_ready); end
    endtask

    // Push and pop together while full: accepted, count stays at 16.
    task automatic test_full_pushpop;
        logic [95:0] f;
        bus.net_ready = 1'b0;
        for (int k = 0; k < 16; k++) put_rand(7'(k + 32), 1'b1);
        f = {$urandom, $urandom, $urandom};
        bus.net_ready = 1'b1;
        bus.wb_in = {3'd1, 3'd2, 3'd3, 7'd99, f};
        bus.wb_valid = 1'b1;
        exp_w = exp_q.pop_front();
        n_tests++; if (bus.net_out !== exp_w) begin n_fail++; $display("FAIL full_head: got %h want %h", bus.net_out, exp_w); end
        exp_q.push_back(pkt(5'd5, 7'd99, f));
        @(negedge clk);
        bus.wb_valid = 1'b0;
        bus.net_ready = 1'b0;
        n_tests++; if (bus.overflow_err !== 1'b0) begin n_fail++; $display("FAIL full_ovf: got %b want 0", bus.overflow_err); end
        bus.net_ready = 1'b1;
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
            if (bus.net_valid) begin
                exp_w = exp_q.pop_front();
                n_tests++; if (bus.net_out !== exp_w) begin n_fail++; $display("FAIL full_out: got %h want %h", bus.net_out, exp_w); end
            end
            @(negedge clk);
        end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_drain: got %0d left want 0", exp_q.size()); exp_q.delete(); end
        bus.net_ready = 1'b0;
    endtask

    task automatic test_overflow;
        bus.net_ready = 1'b0;
        for (int k = 0; k < 17; k++) put_rand(7'(k + 64), k < 16);
        n_tests++; if (bus.overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", bus.overflow_err); end
`ifdef FORCE_WB_ROUTER_STATS_EN
        n_tests++; if (max_fifo_occ !== 5'd16) begin n_fail++; $display("FAIL stats_max: got %0d want 16", max_fifo_occ); end
`endif
        bus.net_ready = 1'b1;
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
            if (bus.net_valid) begin
                exp_w = exp_q.pop_front();
                n_tests++; if (bus.net_out !== exp_w) begin n_fail++; $display("FAIL ovf_out: got %h want %h", bus.net_out, exp_w); end
            end
            @(negedge clk);
        end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ovf_drain: got %0d left want 0", exp_q.size()); exp_q.delete(); end
        n_tests++; if (bus.net_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_17th: got %b want 0", bus.net_valid); end
        bus.net_ready = 1'b0;
    endtask

    task automatic test_bad_id;
        n_tests++; if (bus.bad_id_err !== 1'b0) begin n_fail++; $display("FAIL bad_pre: got %b want 0", bus.bad_id_err); end
        put(3'd0, 3'd2, 3'd2, 7'd1, 96'h1);
        n_tests++; if (bus.local_wr_en !== 1'b0) begin n_fail++; $display("FAIL bad_local: got %b want 0", bus.local_wr_en); end
        n_tests++; if (bus.net_valid !== 1'b0) begin n_fail++; $display("FAIL bad_push: got %b want 0", bus.net_valid); end
        n_tests++; if (bus.bad_id_err !== 1'b1) begin n_fail++; $display("FAIL bad_flag: got %b want 1", bus.bad_id_err); end
        put(3'd4, 3'd1, 3'd1, 7'd2, 96'h2);
        n_tests++; if (bus.net_valid !== 1'b0) begin n_fail++; $display("FAIL bad_push4: got %b want 0", bus.net_valid); end
        n_tests++; if (bus.remote_idle !== 1'b1) begin n_fail++; $display("FAIL bad_idle: got %b want 1", bus.remote_idle); end
    endtask

    task automatic test_reset_mid;
        bus.net_ready = 1'b0;
        for (int k = 0; k < 8; k++) put_rand(7'(k + 100), 1'b1);
        bus.net_ready = 1'b1;
        exp_w = exp_q.pop_front();
        n_tests++; if (bus.net_out !== exp_w) begin n_fail++; $display("FAIL rmid_head: got %h want %h", bus.net_out, exp_w); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.net_ready = 1'b0;
        exp_q.delete();
        n_tests++; if (bus.net_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", bus.net_valid); end
        n_tests++; if (bus.wb_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", bus.wb_ready); end
        n_tests++; if (bus.remote_idle !== 1'b1) begin n_fail++; $display("FAIL rmid_idle: got %b want 1", bus.remote_idle); end
        n_tests++; if ({bus.bad_id_err, bus.overflow_err} !== 2'b00) begin n_fail++; $display("FAIL rmid_errs: got %b want 00", {bus.bad_id_err, bus.overflow_err}); end
`ifdef FORCE_WB_ROUTER_STATS_EN
        n_tests++; if ({local_pkt_cnt, remote_pkt_cnt, max_fifo_occ} !== '0) begin n_fail++; $display("FAIL rmid_stats: got %h/%h/%h want 0", local_pkt_cnt, remote_pkt_cnt, max_fifo_occ); end
`endif
        repeat (2) @(negedge clk);
        n_tests++; if (bus.net_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stay: got %b want 0", bus.net_valid); end
    endtask

    initial begin
        bus.wb_in     = '0;
        bus.wb_valid  = 1'b0;
        bus.net_ready = 1'b0;
        @(negedge clk);
        test_reset;
        test_local;
        test_remote_decode;
        test_backpressure;
        test_full_pushpop;
        test_overflow;
        test_bad_id;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
